// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state encoding and ALU latency default
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  localparam int ALU_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x 8 register file, one write port, three async read ports
module alu_regfile #(
  parameter int NREG = 4,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [RW-1:0] ra_sel,
  output logic [7:0]    ra_data,
  input  logic [RW-1:0] rb_sel,
  output logic [7:0]    rb_data,
  input  logic [RW-1:0] dbg_sel,
  output logic [7:0]    dbg_data
);

  logic [7:0] rf [NREG];

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= 8'h00;
      end
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign ra_data  = rf[ra_sel];
  assign rb_data  = rf[rb_sel];
  assign dbg_data = rf[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - serial issue controller: operand fetch, ALU drive, latency wait, writeback
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREG    = 4,
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int RW      = $clog2(NREG)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_ra,
  input  logic [RW-1:0] instr_rb,
  input  logic          instr_imm_sel,
  input  logic [7:0]    instr_imm,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_ctr,
  input  logic [7:0]    alu_out,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [7:0]    wb_data,
  output logic          wb_zero,
  input  logic [RW-1:0] dbg_sel,
  output logic [7:0]    dbg_data
);

  // WAIT spans ALU_LAT-1 cycles; with ALU_LAT=1 it is skipped entirely.
  localparam int WAIT_CYC = (ALU_LAT > 1) ? ALU_LAT - 1 : 1;
  localparam int CW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rd_q;
  logic [7:0]    ra_data, rb_data;
  logic          accept;

  alu_regfile #(.NREG(NREG), .RW(RW)) u_rf (
    .ck       (ck),
    .rst_n    (rst_n),
    .we       (wb_valid),
    .waddr    (rd_q),
    .wdata    (alu_out),
    .ra_sel   (instr_ra),
    .ra_data  (ra_data),
    .rb_sel   (instr_rb),
    .rb_data  (rb_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  assign accept  = instr_valid & instr_ready;
  assign wb_rd   = rd_q;
  assign wb_data = alu_out;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = ST_ISSUE;
      end
      ST_ISSUE: state_nx = (ALU_LAT > 1) ? ST_WAIT : ST_WB;
      ST_WAIT:  if (cnt == '0) state_nx = ST_WB;
      ST_WB: begin
        wb_valid = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Operand/control registers only move on accept, so they stay stable until WB ends.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_ctr <= 4'h0;
      rd_q    <= '0;
      cnt     <= '0;
      wb_zero <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= ra_data;
        alu_b   <= instr_imm_sel ? instr_imm : rb_data;
        alu_ctr <= instr_op;
        rd_q    <= instr_rd;
      end
      if (state == ST_ISSUE) begin
        cnt <= CW'(WAIT_CYC - 1);
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (wb_valid) begin
        wb_zero <= (alu_out == 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a behavioural two-stage ALU
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int NREG    = 4;
  localparam int RW      = 2;
  localparam int ALU_LAT = 2;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    instr_op = 4'h0;
  logic [RW-1:0] instr_rd = '0;
  logic [RW-1:0] instr_ra = '0;
  logic [RW-1:0] instr_rb = '0;
  logic          instr_imm_sel = 1'b0;
  logic [7:0]    instr_imm = 8'h00;
  logic [7:0]    alu_a, alu_b;
  logic [3:0]    alu_ctr;
  logic [7:0]    alu_out;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [7:0]    wb_data;
  logic          wb_zero;
  logic [RW-1:0] dbg_sel = '0;
  logic [7:0]    dbg_data;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] ref_rf [NREG];
  time        accept_t;

  always #5 ck = ~ck;

  alu_issue_ctrl #(.NREG(NREG), .ALU_LAT(ALU_LAT)) dut (
    .ck            (ck),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_ra      (instr_ra),
    .instr_rb      (instr_rb),
    .instr_imm_sel (instr_imm_sel),
    .instr_imm     (instr_imm),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctr       (alu_ctr),
    .alu_out       (alu_out),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_zero       (wb_zero),
    .dbg_sel       (dbg_sel),
    .dbg_data      (dbg_data)
  );

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHR:  return a >> 1;
      OP_SHL:  return a << 1;
      OP_ROR:  return {a[0], a[7:1]};
      OP_ROL:  return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  // Registered ALU with no reset: inputs captured on one edge, result on the next.
  logic [7:0] a_s, b_s;
  logic [3:0] c_s;
  always @(posedge ck) begin
    a_s     <= alu_a;
    b_s     <= alu_b;
    c_s     <= alu_ctr;
    alu_out <= alu_fn(a_s, b_s, c_s);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input int rd, input int ra, input int rb,
                       input logic imm_sel, input logic [7:0] imm, input logic keep_valid,
                       output time t_acc);
    logic [7:0] exp;
    int         guard;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge ck);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", {31'd0, instr_ready}, 32'd1);
    instr_op      = op;
    instr_rd      = RW'(rd);
    instr_ra      = RW'(ra);
    instr_rb      = RW'(rb);
    instr_imm_sel = imm_sel;
    instr_imm     = imm;
    instr_valid   = 1'b1;
    exp = alu_fn(ref_rf[ra], imm_sel ? imm : ref_rf[rb], op);
    @(posedge ck);
    t_acc = $time;
    @(negedge ck);
    if (!keep_valid) instr_valid = 1'b0;
    for (int n = 1; n <= ALU_LAT + 1; n++) begin
      if (n > 1) @(negedge ck);
      check("ready_busy", {31'd0, instr_ready}, 32'd0);
      check("wb_valid_timing", {31'd0, wb_valid}, {31'd0, (n == ALU_LAT + 1)});
    end
    check("wb_data", {24'd0, wb_data}, {24'd0, exp});
    check("wb_rd", {30'd0, wb_rd}, rd);
    ref_rf[rd] = exp;
    @(negedge ck);
    check("ready_idle", {31'd0, instr_ready}, 32'd1);
    check("wb_valid_drop", {31'd0, wb_valid}, 32'd0);
    check("wb_zero", {31'd0, wb_zero}, {31'd0, (exp == 8'h00)});
    dbg_sel = RW'(rd);
    #1;
    check("dbg_rf", {24'd0, dbg_data}, {24'd0, ref_rf[rd]});
  endtask

  task automatic check_rf_all();
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = RW'(i);
      #1;
      check("dbg_rf_all", {24'd0, dbg_data}, {24'd0, ref_rf[i]});
    end
  endtask

  initial begin
    time t0, t1;
    logic [3:0] op_r;
    for (int i = 0; i < NREG; i++) ref_rf[i] = 8'h00;

    // 1: reset state, then ADD r1 = r0 + 0x25
    #2;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check("rst_alu_ctr", {28'd0, alu_ctr}, 32'd0);
    check("rst_wb_zero", {31'd0, wb_zero}, 32'd0);
    check_rf_all();
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);
    issue(OP_ADD, 1, 0, 0, 1'b1, 8'h25, 1'b0, t0);

    // 2: wrap and zero result
    issue(OP_SUB, 2, 1, 0, 1'b1, 8'h30, 1'b0, t0);
    issue(OP_SUB, 3, 1, 0, 1'b1, 8'h25, 1'b0, t0);

    // 3: unary ops on r1, B from register (ignored)
    issue(OP_ROR, 3, 1, 2, 1'b0, 8'h00, 1'b0, t0);
    issue(OP_ROL, 3, 1, 2, 1'b0, 8'h00, 1'b0, t0);
    issue(OP_SHR, 3, 1, 2, 1'b0, 8'h00, 1'b0, t0);
    issue(OP_SHL, 3, 1, 2, 1'b0, 8'h00, 1'b0, t0);
    issue(OP_NOT, 3, 1, 2, 1'b0, 8'h00, 1'b0, t0);
    check("rf1_kept", {24'd0, ref_rf[1]}, 32'h25);

    // 4: valid held high across two dependent instructions
    issue(OP_ADD, 1, 1, 0, 1'b1, 8'h01, 1'b1, t0);
    issue(OP_ADD, 1, 1, 0, 1'b1, 8'h01, 1'b0, t1);
    check("b2b_spacing", 32'(t1 - t0), 32'((ALU_LAT + 2) * 10));
    check("b2b_result", {24'd0, ref_rf[1]}, 32'h27);

    // 5: undefined opcode writes zero
    issue(4'b0101, 2, 2, 0, 1'b1, 8'h33, 1'b0, t0);

    // 6: reset while waiting on the ALU
    instr_op = OP_ADD; instr_rd = 2'd1; instr_ra = 2'd1; instr_imm_sel = 1'b1; instr_imm = 8'h40;
    instr_valid = 1'b1;
    @(posedge ck);
    @(negedge ck);
    instr_valid = 1'b0;
    @(posedge ck);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) ref_rf[i] = 8'h00;
    check("midrst_ready", {31'd0, instr_ready}, 32'd1);
    check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("midrst_alu_a", {24'd0, alu_a}, 32'd0);
    check("midrst_alu_b", {24'd0, alu_b}, 32'd0);
    check("midrst_alu_ctr", {28'd0, alu_ctr}, 32'd0);
    check("midrst_wb_zero", {31'd0, wb_zero}, 32'd0);
    check_rf_all();
    @(negedge ck);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge ck);
      check("midrst_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    issue(OP_ADD, 1, 0, 0, 1'b1, 8'h11, 1'b0, t0);

    // Randomized traffic against the reference register file
    for (int k = 0; k < 40; k++) begin
      op_r = 4'($urandom_range(0, 15));
      issue(op_r, int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
            int'($urandom_range(0, NREG - 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'b0, t0);
    end
    check_rf_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
